// File: rtl/axis_fir_decimator_if.sv
// Ready/valid stream bundle for the decimated sample output.
// master drives tdata/tvalid and samples tready; slave is the reverse.
interface axis_fir_decimator_if #(
  parameter int W = 32
) ();
  logic signed [W-1:0] tdata;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/axis_fir_decimator.sv
// Decimates the FIR sample stream by N, rounds/shifts, saturates, and
// queues into a 2-entry buffer on M_AXIS; sticky overrun on a full drop.
// Ports: a_clk, a_rst (sync, high), next_dv, deci_n, S_AXIS_tdata,
// S_AXIS_tvalid, M_AXIS (master), overrun, clr_overrun.
module axis_fir_decimator #(
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter int MAXIS_TDATA_WIDTH = 32,
  parameter int DECI_L            = 8,
  parameter int SHIFT             = 0
) (
  input  logic                                a_clk,
  input  logic                                a_rst,
  input  logic                                next_dv,
  input  logic [DECI_L-1:0]                   deci_n,
  input  logic signed [SAXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                                S_AXIS_tvalid,
  axis_fir_decimator_if.master                M_AXIS,
  output logic                                overrun,
  input  logic                                clr_overrun
);

  localparam int SW = SAXIS_TDATA_WIDTH;
  localparam int MW = MAXIS_TDATA_WIDTH;
  localparam int XW = SW + 1;

  // 1 << (SHIFT-1), or 0 when no shift
  localparam logic [XW:0] RND_W =
    ({{XW{1'b0}}, 1'b1} << SHIFT) >> 1;
  localparam logic signed [XW-1:0] RND =
    RND_W[XW-1:0];

  localparam logic signed [XW-1:0] SAT_MAX =
    {{(XW-MW+1){1'b0}}, {(MW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN =
    {{(XW-MW+1){1'b1}}, {(MW-1){1'b0}}};

  // phase counter
  logic [DECI_L-1:0] phase;
  logic [DECI_L-1:0] n_lat;
  logic [DECI_L-1:0] n_in;
  logic [DECI_L-1:0] n_cur;
  logic [DECI_L:0]   phase_inc;
  logic              strobe;
  logic              capture;
  logic              wrap;

  assign strobe    = next_dv & S_AXIS_tvalid;
  assign capture   = strobe & (phase == '0);
  assign n_in      = (deci_n == '0) ? DECI_L'(1) : deci_n;
  // N is only re-latched at phase 0
  assign n_cur     = (phase == '0) ? n_in : n_lat;
  assign phase_inc = {1'b0, phase} + 1'b1;
  assign wrap      = (phase_inc == {1'b0, n_cur});

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      phase <= '0;
      n_lat <= DECI_L'(1);
    end else if (!S_AXIS_tvalid) begin
      phase <= '0;
    end else if (strobe) begin
      if (phase == '0)
        n_lat <= n_in;
      phase <= wrap ? '0 : phase_inc[DECI_L-1:0];
    end
  end

  // stage 1: round half up, arithmetic shift
  logic signed [XW-1:0] x_ext;
  logic signed [XW-1:0] x_sum;
  logic signed [XW-1:0] s1_data;
  logic                 s1_valid;

  assign x_ext = {S_AXIS_tdata[SW-1], S_AXIS_tdata};
  assign x_sum = x_ext + RND;

  // stage 2: saturate to output width
  logic signed [MW-1:0] sat;
  logic signed [MW-1:0] s2_data;
  logic                 s2_valid;

  always_comb begin
    sat = s1_data[MW-1:0];
    if (s1_data > SAT_MAX)
      sat = SAT_MAX[MW-1:0];
    else if (s1_data < SAT_MIN)
      sat = SAT_MIN[MW-1:0];
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s1_valid <= capture;
      if (capture)
        s1_data <= x_sum >>> SHIFT;
      s2_valid <= s1_valid;
      if (s1_valid)
        s2_data <= sat;
    end
  end

  // 2-entry output buffer
  logic signed [MW-1:0] mem [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           count;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 accept;
  logic                 drop;

  assign push   = s2_valid;
  assign pop    = M_AXIS.tvalid & M_AXIS.tready;
  assign full   = (count == 2'd2);
  // a pop frees the slot the push lands in
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      mem     <= '{default: '0};
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= s2_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      unique case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

  assign M_AXIS.tvalid = (count != 2'd0);
  assign M_AXIS.tdata  = mem[rd_ptr];

endmodule
